// File: rtl/fp16_green_pkg.sv
// Shared types and encodings for the GreenFloat issue stage.
package fp16_green_pkg;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_MUL    = 2'b10;
    localparam logic       MODE_FP32 = 1'b0;
    localparam logic       MODE_FP16 = 1'b1;

    typedef struct packed {
        logic        mode;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } gf_cmd_t;

    typedef enum logic [1:0] {
        GI_IDLE,
        GI_ISSUE,
        GI_DRAIN
    } gf_issue_state_t;

    function automatic logic gf_op_legal(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/gf_cmd_fifo.sv
// Command FIFO for the GreenFloat issue stage. Besides the current head it exposes the head cfg
// as it will be after this cycle's push/pop, so the issue FSM can register its next state.
module gf_cmd_fifo
    import fp16_green_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  gf_cmd_t    wdata_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output gf_cmd_t    head_o,
    output logic       nxt_empty_o,
    output logic       nxt_mode_o,
    output logic [1:0] nxt_op_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [PtrW-1:0] wr_idx, rd_idx, rd_nxt_idx;
    logic            push_ok, pop_ok;
    gf_cmd_t         mem_q [DEPTH];

    assign wr_idx      = wr_q[PtrW-1:0];
    assign rd_idx      = rd_q[PtrW-1:0];
    assign empty_o     = (wr_q == rd_q);
    assign full_o      = (wr_q[PtrW] != rd_q[PtrW]) && (wr_idx == rd_idx);
    assign push_ok     = push_i && !full_o;
    assign pop_ok      = pop_i && !empty_o;
    assign wr_d        = wr_q + {{PtrW{1'b0}}, push_ok};
    assign rd_d        = rd_q + {{PtrW{1'b0}}, pop_ok};
    assign rd_nxt_idx  = rd_d[PtrW-1:0];
    assign head_o      = mem_q[rd_idx];
    assign nxt_empty_o = (wr_d == rd_d);

    // A push landing in the slot that becomes the head bypasses the array.
    always_comb begin
        if (push_ok && (rd_nxt_idx == wr_idx)) begin
            nxt_mode_o = wdata_i.mode;
            nxt_op_o   = wdata_i.op;
        end else begin
            nxt_mode_o = mem_q[rd_nxt_idx].mode;
            nxt_op_o   = mem_q[rd_nxt_idx].op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_idx] <= wdata_i;
        end
    end

endmodule

// File: rtl/greenfloat_issue_ctrl.sv
// GreenFloat issue stage: queues FP commands, issues them to the core, tracks ops in flight.
// Define GREENFLOAT_ISSUE_PERF_EN to build the saturating stall_cycles counter.
module greenfloat_issue_ctrl
    import fp16_green_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_mode_i,
    input  logic [1:0]  cmd_op_i,
    input  logic [31:0] cmd_a_i,
    input  logic [31:0] cmd_b_i,
    output logic        core_valid_in_o,
    output logic        core_mode_o,
    output logic [1:0]  core_operation_o,
    output logic [31:0] core_a32_o,
    output logic [31:0] core_b32_o,
    output logic [15:0] core_a16_o,
    output logic [15:0] core_b16_o,
    input  logic        core_valid_out_i,
    output logic [3:0]  inflight_o,
    output logic        busy_o,
    output logic [15:0] switch_count_o,
    output logic [15:0] stall_cycles_o,
    output logic        err_illegal_o,
    output logic        err_spurious_o
);
    localparam logic [3:0] MaxCnt = 4'(MAX_INFLIGHT);

    gf_issue_state_t state_q, state_d;
    gf_cmd_t         wdata, head;
    logic            fifo_full, fifo_empty, nxt_empty, nxt_mode;
    logic [1:0]      nxt_op;
    logic            head_legal, cfg_match, issue, drop, ret_ok;

    logic        valid_q, valid_d, mode_q, mode_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  inflight_q, inflight_d;
    logic [15:0] switch_q, switch_d;
    logic        ill_q, ill_d, spur_q, spur_d;

    assign wdata = '{mode: cmd_mode_i, op: cmd_op_i, a: cmd_a_i, b: cmd_b_i};

    gf_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (cmd_valid_i),
        .wdata_i    (wdata),
        .pop_i      (issue || drop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (head),
        .nxt_empty_o(nxt_empty),
        .nxt_mode_o (nxt_mode),
        .nxt_op_o   (nxt_op)
    );

    // GI_ISSUE already guarantees a non-empty FIFO and a cfg that may be loaded now.
    always_comb begin
        head_legal = gf_op_legal(head.op);
        cfg_match  = (head.mode == mode_q) && (head.op == op_q);
        issue      = (state_q == GI_ISSUE) && head_legal && (inflight_q < MaxCnt);
        drop       = !fifo_empty && !head_legal;
        ret_ok     = core_valid_out_i && (inflight_q != 4'd0);

        valid_d  = issue;
        mode_d   = mode_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        switch_d = switch_q;
        ill_d    = drop;
        spur_d   = core_valid_out_i && (inflight_q == 4'd0);
        if (issue) begin
            mode_d = head.mode;
            op_d   = head.op;
            a_d    = head.a;
            b_d    = head.b;
            if ((inflight_q == 4'd0) && !cfg_match) begin
                switch_d = switch_q + 16'd1;
            end
        end

        case ({issue, ret_ok})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    // Next state classifies the cycle that follows, using the post-update head, cfg and count.
    always_comb begin
        state_d = state_q;
        if (nxt_empty) begin
            state_d = GI_IDLE;
        end else if (((nxt_mode == mode_d) && (nxt_op == op_d)) || (inflight_d == 4'd0)) begin
            state_d = GI_ISSUE;
        end else begin
            state_d = GI_DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GI_IDLE;
            valid_q    <= 1'b0;
            mode_q     <= MODE_FP32;
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            inflight_q <= '0;
            switch_q   <= '0;
            ill_q      <= 1'b0;
            spur_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            mode_q     <= mode_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            inflight_q <= inflight_d;
            switch_q   <= switch_d;
            ill_q      <= ill_d;
            spur_q     <= spur_d;
        end
    end

`ifdef GREENFLOAT_ISSUE_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!fifo_empty && !issue && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = 16'h0;
`endif

    assign cmd_ready_o      = !fifo_full;
    assign core_valid_in_o  = valid_q;
    assign core_mode_o      = mode_q;
    assign core_operation_o = op_q;
    assign core_a32_o       = a_q;
    assign core_b32_o       = b_q;
    assign core_a16_o       = a_q[15:0];
    assign core_b16_o       = b_q[15:0];
    assign inflight_o       = inflight_q;
    assign busy_o           = !fifo_empty || (inflight_q != 4'd0);
    assign switch_count_o   = switch_q;
    assign err_illegal_o    = ill_q;
    assign err_spurious_o   = spur_q;

endmodule
